inv_sigmoid_stream: RTL and testbench

// - Inverse of the layer-1 sigmoid: maps a 7-bit activation code (legal 0..15) back to a
//   7-bit two's-complement pre-activation code. Feeds the backward/debug path of the CNN.
// - Streaming block: valid/ready in and out, 2-stage pipeline, saturation/error tagging,

---
 rtl/cnn_act_pkg.sv | 18 +
 rtl/inv_sigmoid_rom.sv | 12 +
 rtl/inv_sigmoid_stream.sv | 83 ++++++++
 tb/tb_inv_sigmoid_stream.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_act_pkg.sv
// Shared constants for the layer-1 activation path: bus width, inverse-sigmoid
// table and the activation codes that mark the clamped ends of the sigmoid.
package cnn_act_pkg;

    localparam int ACT_W = 7;

    localparam logic [3:0] SAT_LO = 4'd0;
    localparam logic [3:0] SAT_HI = 4'd15;

    // Pre-activation code for each legal activation 0..15, two's complement.
    localparam logic signed [ACT_W-1:0] INV_SIG_LUT [16] = '{
        ACT_W'(-64), ACT_W'(-40), ACT_W'(-28), ACT_W'(-20),
        ACT_W'(-14), ACT_W'(-11), ACT_W'(-6),  ACT_W'(-2),
        ACT_W'(4),   ACT_W'(8),   ACT_W'(12),  ACT_W'(16),
        ACT_W'(20),  ACT_W'(29),  ACT_W'(40),  ACT_W'(63)
    };

endpackage

// File: rtl/inv_sigmoid_rom.sv
// Combinational inverse-sigmoid lookup: 4-bit activation index to
// pre-activation code.
module inv_sigmoid_rom
    import cnn_act_pkg::*;
(
    input  logic [3:0]       idx,
    output logic [ACT_W-1:0] code
);

    assign code = INV_SIG_LUT[idx];

endmodule

// File: rtl/inv_sigmoid_stream.sv
// Streaming inverse sigmoid: two-stage valid/ready pipeline mapping activation
// codes back to pre-activation codes, with clamp/illegal tagging and a sample count.
module inv_sigmoid_stream #(
    parameter int ACT_W = 7,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACT_W-1:0] in_act,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACT_W-1:0] out_pre,
    output logic             out_sat,
    output logic             out_err,
    output logic [CNT_W-1:0] sample_cnt
);

    import cnn_act_pkg::*;

    logic             vld_p1;
    logic [3:0]       idx_p1;
    logic             err_p1;
    logic [ACT_W-1:0] rom_code_p1;
    logic             s1_en;
    logic             s2_en;

    // Illegal activations are forced to zero rather than aliased into the table.
    function automatic logic [ACT_W-1:0] clamp_pre(input logic [ACT_W-1:0] code,
                                                   input logic err);
        return err ? '0 : code;
    endfunction

    function automatic logic sat_flag(input logic [3:0] idx, input logic err);
        return !err && ((idx == SAT_LO) || (idx == SAT_HI));
    endfunction

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !vld_p1 || s2_en;
    assign in_ready = s1_en;

    // ---- stage S1: capture activation and range error ----
    always_ff @(posedge clk) begin
        if (s1_en) begin
            idx_p1 <= in_act[3:0];
            err_p1 <= |in_act[ACT_W-1:4];
        end
    end

    inv_sigmoid_rom u_rom (
        .idx  (idx_p1),
        .code (rom_code_p1)
    );

    // ---- stage S2: table lookup, flags, output handshake and counter ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            out_valid  <= 1'b0;
            out_pre    <= '0;
            out_sat    <= 1'b0;
            out_err    <= 1'b0;
            sample_cnt <= '0;
        end else begin
            if (s1_en) begin
                vld_p1 <= in_valid;
            end
            if (s2_en) begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    out_pre <= clamp_pre(rom_code_p1, err_p1);
                    out_sat <= sat_flag(idx_p1, err_p1);
                    out_err <= err_p1;
                end
            end
            if (out_valid && out_ready) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inv_sigmoid_stream.sv
// Scoreboard bench for inv_sigmoid_stream: directed scenarios plus randomized
// traffic with random back-pressure against a table-based reference model.
module tb_inv_sigmoid_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_act;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_pre;
    logic        out_sat;
    logic        out_err;
    logic [15:0] sample_cnt;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [6:0]  w_out_pre;
    logic        w_out_sat;
    logic        w_out_err;
    logic [3:0]  w_cnt;

    always #5 clk = ~clk;

    inv_sigmoid_stream #(.ACT_W(7), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .out_valid(out_valid), .out_ready(out_ready),
        .out_pre(out_pre), .out_sat(out_sat), .out_err(out_err),
        .sample_cnt(sample_cnt)
    );

    // Narrow-counter instance fed the same stream, used for the wrap check.
    inv_sigmoid_stream #(.ACT_W(7), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_act(in_act), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_pre(w_out_pre), .out_sat(w_out_sat), .out_err(w_out_err),
        .sample_cnt(w_cnt)
    );

    typedef struct {
        int pre;
        bit sat;
        bit err;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   model_cnt = 0;
    bit   rand_bp   = 1'b0;

    int lut[16] = '{-64, -40, -28, -20, -14, -11, -6, -2,
                    4, 8, 12, 16, 20, 29, 40, 63};

    function automatic exp_t model(input int a);
        exp_t e;
        e.err = (a > 15);
        e.sat = (a == 0) || (a == 15);
        e.pre = e.err ? 0 : lut[a];
        return e;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int a);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_act   = 7'(a);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc && rst_n) begin
                q.push_back(model(a));
                done = 1'b1;
            end
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        bit   stall;
        int   held_pre;
        int   held_sat;
        int   held_err;
        stall = 1'b0;
        held_pre = 0;
        held_sat = 0;
        held_err = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                model_cnt = 0;
                stall     = 1'b0;
            end else begin
                check("sample_cnt", int'(sample_cnt), model_cnt % 65536);
                check("wrap_cnt", int'(w_cnt), model_cnt % 16);
                if (stall) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_pre", $signed(out_pre), held_pre);
                    check("hold_sat", int'(out_sat), held_sat);
                    check("hold_err", int'(out_err), held_err);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("out_pre", $signed(out_pre), e.pre);
                        check("out_sat", int'(out_sat), int'(e.sat));
                        check("out_err", int'(out_err), int'(e.err));
                    end
                    model_cnt++;
                end
                stall = out_valid && !out_ready;
                if (stall) begin
                    held_pre = $signed(out_pre);
                    held_sat = int'(out_sat);
                    held_err = int'(out_err);
                end
            end
        end
    end

    // Random back-pressure generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got %0d expected %0d", 0, 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_act    = 7'd5;
        out_ready = 1'b1;

        // Reset held with valid input pending
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sample_cnt", int'(sample_cnt), 0);
        check("rst_out_pre", int'(out_pre), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle(4);
        check("post_rst_quiet", int'(out_valid), 0);

        // Single sample and latency
        send(8);
        in_valid = 1'b0;
        check("lat_early", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_valid", int'(out_valid), 1);
        check("lat_pre", $signed(out_pre), 4);
        @(posedge clk); #1;
        check("single_cnt", int'(sample_cnt), 1);

        // Full-table burst
        for (int a = 0; a < 16; a++) send(a);
        idle(3);
        check("burst_cnt", int'(sample_cnt), 17);

        // Back-pressure: two accepted, third blocked
        out_ready = 1'b0;
        send(3);
        send(9);
        in_valid = 1'b1;
        in_act   = 7'd14;
        repeat (5) begin
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_pre", $signed(out_pre), -20);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(14);
        idle(4);
        check("bp_cnt", int'(sample_cnt), 20);

        // Illegal input then legal
        send(20);
        send(5);
        idle(4);
        check("illegal_cnt", int'(sample_cnt), 22);

        // Reset with both stages full, then counter wrap
        out_ready = 1'b0;
        send(1);
        send(2);
        in_valid = 1'b0;
        check("full_before_rst", int'(out_valid), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_cnt", int'(sample_cnt), 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        for (int i = 0; i < 17; i++) send(i % 16);
        idle(4);
        check("wrap_17", int'(w_cnt), 1);
        check("full_17", int'(sample_cnt), 17);

        // Randomized traffic with random back-pressure
        rand_bp = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) send(int'($urandom_range(16, 127)));
            else send(int'($urandom_range(0, 15)));
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        in_valid = 1'b0;
        rand_bp  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(6);
        check("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
